// File: rtl/digital_timer_updown.sv
// digital_timer_updown
//   Six-digit BCD HH:MM:SS timer that counts up or down at one tick every
//   TICK_DIV sys_clk cycles. It supports a synchronous preset load and a
//   configurable hour modulus. It drives registered 7-segment patterns plus
//   tick/wrap/expiry status flags.
//
// Parameters
//   TICK_DIV       sys_clk cycles per counted second (2..65535)
//   HR_WRAP        hour modulus (2..99); count-up wraps (HR_WRAP-1):59:59 -> 0
//   SEG_ACTIVE_LOW 1 = segment lit when bit is 0, 0 = lit when bit is 1
//
// Ports
//   sys_clk            system clock
//   int_reset_b        asynchronous active-low reset
//   timer_clear        synchronous clear of digits, prescaler and flags
//   timer_pause        hold prescaler and digits
//   count_down         0 = count up, 1 = count down (applies at next tick)
//   load_en            one-cycle strobe loading load_value (if valid)
//   load_value[23:0]   preset, six BCD nibbles, [3:0] = sec units
//   digits_bcd[23:0]   current value, same packing as load_value
//   digital_clock_out  6 x 7-bit segment patterns {a..g}, index 0 = sec units
//   tick_pulse         one-cycle pulse after each counted second
//   wrap_pulse         one-cycle pulse after a count-up wrap to 00:00:00
//   expired            sticky, set when count-down reaches 00:00:00
module digital_timer_updown #(
  parameter int unsigned TICK_DIV       = 10,
  parameter int unsigned HR_WRAP        = 24,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            sys_clk,
  input  logic            int_reset_b,
  input  logic            timer_clear,
  input  logic            timer_pause,
  input  logic            count_down,
  input  logic            load_en,
  input  logic [23:0]     load_value,
  output logic [23:0]     digits_bcd,
  output logic [5:0][6:0] digital_clock_out,
  output logic            tick_pulse,
  output logic            wrap_pulse,
  output logic            expired
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  HR_LAST_T  = 4'((HR_WRAP - 1) / 10);
  localparam logic [3:0]  HR_LAST_U  = 4'((HR_WRAP - 1) % 10);
  localparam logic [7:0]  HR_LIMIT   = 8'(HR_WRAP);

  // Segment pattern for one BCD digit, {a,b,c,d,e,f,g} with a in bit 6.
  // Non-BCD codes blank the digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] pat;
    case (d)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = 7'b1111111;
    endcase
    return SEG_ACTIVE_LOW ? pat : ~pat;
  endfunction

  logic [15:0] presc_q;
  logic [23:0] digits_q;
  logic        tick_q;
  logic        wrap_q;
  logic        expired_q;
  logic [5:0][6:0] seg_q;

  logic [3:0]  s0, s1, m0, m1, h0, h1;
  logic [3:0]  l_s0, l_s1, l_m0, l_m1, l_h0, l_h1;
  logic [7:0]  load_hr;
  logic        load_ok;
  logic        presc_hit;
  logic        at_zero;
  logic        at_top;
  logic        tick_en;
  logic [23:0] next_up;
  logic [23:0] next_down;

  always_comb begin
    {h1, h0, m1, m0, s1, s0} = digits_q;
    {l_h1, l_h0, l_m1, l_m0, l_s1, l_s0} = load_value;

    load_hr = ({4'd0, l_h1} * 8'd10) + {4'd0, l_h0};
    load_ok = (l_s0 <= 4'd9) && (l_s1 <= 4'd5) &&
              (l_m0 <= 4'd9) && (l_m1 <= 4'd5) &&
              (l_h0 <= 4'd9) && (l_h1 <= 4'd9) &&
              (load_hr < HR_LIMIT);

    presc_hit = (presc_q == PRESC_LAST);
    at_zero   = (digits_q == '0);
    at_top    = (s0 == 4'd9) && (s1 == 4'd5) && (m0 == 4'd9) && (m1 == 4'd5) &&
                (h0 == HR_LAST_U) && (h1 == HR_LAST_T);
    // A count-down parked at zero swallows its ticks; the prescaler keeps going.
    tick_en   = presc_hit && !(count_down && at_zero);
  end

  // Count-up carry chain.
  always_comb begin
    logic [3:0] n_s0, n_s1, n_m0, n_m1, n_h0, n_h1;
    n_s0 = s0; n_s1 = s1; n_m0 = m0; n_m1 = m1; n_h0 = h0; n_h1 = h1;
    if (s0 != 4'd9) begin
      n_s0 = s0 + 4'd1;
    end else begin
      n_s0 = 4'd0;
      if (s1 != 4'd5) begin
        n_s1 = s1 + 4'd1;
      end else begin
        n_s1 = 4'd0;
        if (m0 != 4'd9) begin
          n_m0 = m0 + 4'd1;
        end else begin
          n_m0 = 4'd0;
          if (m1 != 4'd5) begin
            n_m1 = m1 + 4'd1;
          end else begin
            n_m1 = 4'd0;
            if ((h1 == HR_LAST_T) && (h0 == HR_LAST_U)) begin
              n_h1 = 4'd0;
              n_h0 = 4'd0;
            end else if (h0 != 4'd9) begin
              n_h0 = h0 + 4'd1;
            end else begin
              n_h0 = 4'd0;
              n_h1 = h1 + 4'd1;
            end
          end
        end
      end
    end
    next_up = {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
  end

  // Count-down borrow chain; never evaluated at 00:00:00 because tick_en
  // blocks that case, so the hours never underflow.
  always_comb begin
    logic [3:0] n_s0, n_s1, n_m0, n_m1, n_h0, n_h1;
    n_s0 = s0; n_s1 = s1; n_m0 = m0; n_m1 = m1; n_h0 = h0; n_h1 = h1;
    if (s0 != 4'd0) begin
      n_s0 = s0 - 4'd1;
    end else begin
      n_s0 = 4'd9;
      if (s1 != 4'd0) begin
        n_s1 = s1 - 4'd1;
      end else begin
        n_s1 = 4'd5;
        if (m0 != 4'd0) begin
          n_m0 = m0 - 4'd1;
        end else begin
          n_m0 = 4'd9;
          if (m1 != 4'd0) begin
            n_m1 = m1 - 4'd1;
          end else begin
            n_m1 = 4'd5;
            if (h0 != 4'd0) begin
              n_h0 = h0 - 4'd1;
            end else begin
              n_h0 = 4'd9;
              n_h1 = h1 - 4'd1;
            end
          end
        end
      end
    end
    next_down = {n_h1, n_h0, n_m1, n_m0, n_s1, n_s0};
  end

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      presc_q   <= '0;
      digits_q  <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (timer_clear) begin
        presc_q   <= '0;
        digits_q  <= '0;
        expired_q <= 1'b0;
      end else if (load_en && load_ok) begin
        presc_q   <= '0;
        digits_q  <= load_value;
        expired_q <= 1'b0;
      end else if (!timer_pause) begin
        // An invalid load falls through here so counting is undisturbed.
        presc_q <= presc_hit ? '0 : presc_q + 16'd1;
        if (tick_en) begin
          tick_q <= 1'b1;
          if (count_down) begin
            digits_q <= next_down;
            if (next_down == '0) begin
              expired_q <= 1'b1;
            end
          end else begin
            digits_q <= next_up;
            wrap_q   <= at_top;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      for (int unsigned i = 0; i < 6; i++) begin
        seg_q[i] <= seg_encode(4'd0);
      end
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        seg_q[i] <= seg_encode(digits_q[4*i +: 4]);
      end
    end
  end

  assign digits_bcd        = digits_q;
  assign digital_clock_out = seg_q;
  assign tick_pulse        = tick_q;
  assign wrap_pulse        = wrap_q;
  assign expired           = expired_q;

endmodule

// File: tb/tb_digital_timer_updown.sv
// Directed bench for digital_timer_updown. Two instances share the stimulus:
// dut_a (HR_WRAP=24, active-low segments) and dut_b (HR_WRAP=12, active-high
// segments). Inputs change and outputs are sampled on the falling edge.
module tb_digital_timer_updown;

  localparam logic [6:0] SEG0 = 7'b0000001;
  localparam logic [6:0] SEG1 = 7'b1001111;
  localparam logic [6:0] SEG2 = 7'b0010010;

  logic sys_clk = 1'b0;
  logic int_reset_b;
  logic timer_clear;
  logic timer_pause;
  logic count_down;
  logic load_en;
  logic [23:0] load_value;

  logic [23:0]     a_digits, b_digits;
  logic [5:0][6:0] a_seg, b_seg;
  logic            a_tick, b_tick, a_wrap, b_wrap, a_exp, b_exp;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  digital_timer_updown #(.TICK_DIV(10), .HR_WRAP(24), .SEG_ACTIVE_LOW(1'b1)) dut_a (
    .sys_clk(sys_clk), .int_reset_b(int_reset_b), .timer_clear(timer_clear),
    .timer_pause(timer_pause), .count_down(count_down), .load_en(load_en),
    .load_value(load_value), .digits_bcd(a_digits), .digital_clock_out(a_seg),
    .tick_pulse(a_tick), .wrap_pulse(a_wrap), .expired(a_exp));

  digital_timer_updown #(.TICK_DIV(10), .HR_WRAP(12), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .sys_clk(sys_clk), .int_reset_b(int_reset_b), .timer_clear(timer_clear),
    .timer_pause(timer_pause), .count_down(count_down), .load_en(load_en),
    .load_value(load_value), .digits_bcd(b_digits), .digital_clock_out(b_seg),
    .tick_pulse(b_tick), .wrap_pulse(b_wrap), .expired(b_exp));

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // One-cycle load strobe; leaves the clock at the negedge after the load edge.
  task automatic do_load(input logic [23:0] v);
    load_value = v;
    load_en    = 1'b1;
    step(1);
    load_en    = 1'b0;
  endtask

  task automatic test_reset;
    int_reset_b = 1'b0;
    timer_clear = 1'b0; timer_pause = 1'b0; count_down = 1'b0;
    load_en = 1'b0; load_value = '0;
    step(2);
    checks++; if (a_digits !== 24'h0) begin failures++; $display("FAIL reset_digits got=%h exp=000000", a_digits); end
    checks++; if ({a_tick, a_wrap, a_exp} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {a_tick, a_wrap, a_exp}); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (a_seg[i] !== SEG0) begin failures++; $display("FAIL reset_seg_a[%0d] got=%b exp=%b", i, a_seg[i], SEG0); end
      checks++; if (b_seg[i] !== ~SEG0) begin failures++; $display("FAIL reset_seg_b[%0d] got=%b exp=%b", i, b_seg[i], ~SEG0); end
    end
    int_reset_b = 1'b1;
  endtask

  task automatic test_count_up;
    int ticks;
    step(9);
    checks++; if (a_digits !== 24'h0 || a_tick !== 1'b0) begin failures++; $display("FAIL up_pre_tick got=%h/%b exp=000000/0", a_digits, a_tick); end
    step(1);
    checks++; if (a_digits !== 24'h000001) begin failures++; $display("FAIL up_first got=%h exp=000001", a_digits); end
    checks++; if (a_tick !== 1'b1) begin failures++; $display("FAIL up_first_tick got=%b exp=1", a_tick); end
    checks++; if (a_seg[0] !== SEG0) begin failures++; $display("FAIL up_seg_lag got=%b exp=%b", a_seg[0], SEG0); end
    step(1);
    checks++; if (a_seg[0] !== SEG1) begin failures++; $display("FAIL up_seg_one got=%b exp=%b", a_seg[0], SEG1); end
    checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL up_tick_width got=%b exp=0", a_tick); end
    ticks = 0;
    for (int i = 0; i < 89; i++) begin
      step(1);
      if (a_tick === 1'b1) ticks++;
    end
    checks++; if (ticks != 9) begin failures++; $display("FAIL up_tick_count got=%0d exp=9", ticks); end
    checks++; if (a_digits !== 24'h000010) begin failures++; $display("FAIL up_ten got=%h exp=000010", a_digits); end
  endtask

  task automatic test_wrap24;
    do_load(24'h235959);
    checks++; if (a_digits !== 24'h235959) begin failures++; $display("FAIL wrap24_load got=%h exp=235959", a_digits); end
    step(9);
    checks++; if (a_digits !== 24'h235959 || a_wrap !== 1'b0) begin failures++; $display("FAIL wrap24_hold got=%h/%b exp=235959/0", a_digits, a_wrap); end
    step(1);
    checks++; if (a_digits !== 24'h000000) begin failures++; $display("FAIL wrap24_value got=%h exp=000000", a_digits); end
    checks++; if (a_wrap !== 1'b1 || a_tick !== 1'b1) begin failures++; $display("FAIL wrap24_pulse got=%b%b exp=11", a_wrap, a_tick); end
    step(1);
    checks++; if (a_wrap !== 1'b0) begin failures++; $display("FAIL wrap24_width got=%b exp=0", a_wrap); end
  endtask

  task automatic test_wrap12;
    do_load(24'h115959);
    step(10);
    checks++; if (b_digits !== 24'h000000 || b_wrap !== 1'b1) begin failures++; $display("FAIL wrap12 got=%h/%b exp=000000/1", b_digits, b_wrap); end
    checks++; if (a_digits !== 24'h120000 || a_wrap !== 1'b0) begin failures++; $display("FAIL hour_bcd got=%h/%b exp=120000/0", a_digits, a_wrap); end
    step(1);
    checks++; if (b_wrap !== 1'b0) begin failures++; $display("FAIL wrap12_width got=%b exp=0", b_wrap); end
    checks++; if (b_seg[0] !== ~SEG0) begin failures++; $display("FAIL seg_active_high got=%b exp=%b", b_seg[0], ~SEG0); end
    checks++; if (a_seg[4] !== SEG2 || a_seg[5] !== SEG1) begin failures++; $display("FAIL seg_hours got=%b_%b exp=%b_%b", a_seg[5], a_seg[4], SEG1, SEG2); end
  endtask

  task automatic test_count_down;
    int ticks;
    logic bad;
    count_down = 1'b1;
    do_load(24'h000003);
    checks++; if (a_digits !== 24'h000003 || a_exp !== 1'b0) begin failures++; $display("FAIL down_load got=%h/%b exp=000003/0", a_digits, a_exp); end
    step(10);
    checks++; if (a_digits !== 24'h000002) begin failures++; $display("FAIL down_2 got=%h exp=000002", a_digits); end
    step(10);
    checks++; if (a_digits !== 24'h000001 || a_exp !== 1'b0) begin failures++; $display("FAIL down_1 got=%h/%b exp=000001/0", a_digits, a_exp); end
    step(10);
    checks++; if (a_digits !== 24'h000000 || a_exp !== 1'b1 || a_tick !== 1'b1) begin failures++; $display("FAIL down_0 got=%h/%b/%b exp=000000/1/1", a_digits, a_exp, a_tick); end
    ticks = 0; bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (a_tick === 1'b1) ticks++;
      if (a_digits !== 24'h0 || a_exp !== 1'b1) bad = 1'b1;
    end
    checks++; if (ticks != 0) begin failures++; $display("FAIL down_hold_ticks got=%0d exp=0", ticks); end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL down_hold_value got=%b exp=0", bad); end
    count_down = 1'b0;
    step(10);
    checks++; if (a_digits !== 24'h000001 || a_exp !== 1'b1) begin failures++; $display("FAIL resume_up got=%h/%b exp=000001/1", a_digits, a_exp); end
  endtask

  task automatic test_borrow_and_invalid;
    count_down = 1'b1;
    do_load(24'h000100);
    checks++; if (a_exp !== 1'b0) begin failures++; $display("FAIL load_clears_expired got=%b exp=0", a_exp); end
    step(10);
    checks++; if (a_digits !== 24'h000059) begin failures++; $display("FAIL borrow_min got=%h exp=000059", a_digits); end
    do_load(24'h000070);
    checks++; if (a_digits !== 24'h000059) begin failures++; $display("FAIL invalid_load got=%h exp=000059", a_digits); end
    step(8);
    checks++; if (a_digits !== 24'h000059) begin failures++; $display("FAIL invalid_presc got=%h exp=000059", a_digits); end
    step(1);
    checks++; if (a_digits !== 24'h000058) begin failures++; $display("FAIL invalid_continue got=%h exp=000058", a_digits); end
  endtask

  task automatic test_pause_and_clear;
    int ticks;
    logic bad;
    count_down = 1'b0;
    do_load(24'h000500);
    step(4);
    timer_pause = 1'b1;
    ticks = 0; bad = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step(1);
      if (a_tick === 1'b1) ticks++;
      if (a_digits !== 24'h000500) bad = 1'b1;
    end
    timer_pause = 1'b0;
    checks++; if (ticks != 0 || bad !== 1'b0) begin failures++; $display("FAIL pause_hold got=%0d/%b exp=0/0", ticks, bad); end
    step(5);
    checks++; if (a_digits !== 24'h000500) begin failures++; $display("FAIL pause_remaining got=%h exp=000500", a_digits); end
    step(1);
    checks++; if (a_digits !== 24'h000501 || a_tick !== 1'b1) begin failures++; $display("FAIL pause_resume got=%h/%b exp=000501/1", a_digits, a_tick); end
    timer_clear = 1'b1;
    do_load(24'h123456);
    timer_clear = 1'b0;
    checks++; if (a_digits !== 24'h000000 || a_tick !== 1'b0) begin failures++; $display("FAIL clear_over_load got=%h/%b exp=000000/0", a_digits, a_tick); end
  endtask

  task automatic test_async_reset;
    do_load(24'h000042);
    step(10);
    checks++; if (a_digits !== 24'h000043 || a_tick !== 1'b1) begin failures++; $display("FAIL pre_reset got=%h/%b exp=000043/1", a_digits, a_tick); end
    #2 int_reset_b = 1'b0;
    #1;
    checks++; if (a_digits !== 24'h0 || b_digits !== 24'h0) begin failures++; $display("FAIL async_digits got=%h/%h exp=000000", a_digits, b_digits); end
    checks++; if ({a_tick, a_wrap, a_exp} !== 3'b000) begin failures++; $display("FAIL async_flags got=%b exp=000", {a_tick, a_wrap, a_exp}); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (a_seg[i] !== SEG0) begin failures++; $display("FAIL async_seg[%0d] got=%b exp=%b", i, a_seg[i], SEG0); end
    end
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    step(9);
    checks++; if (a_digits !== 24'h0) begin failures++; $display("FAIL post_reset_hold got=%h exp=000000", a_digits); end
    step(1);
    checks++; if (a_digits !== 24'h000001) begin failures++; $display("FAIL post_reset_count got=%h exp=000001", a_digits); end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_wrap24;
    test_wrap12;
    test_count_down;
    test_borrow_and_invalid;
    test_pause_and_clear;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digital_timer_updown.md
Name: digital_timer_updown

Overview:
- Parametrised successor to the fixed count-up HH:MM:SS timer.
- Keeps six BCD digits (HH:MM:SS) and counts up or down at a programmable tick rate derived from sys_clk.
- Supports synchronous preset load and a configurable hour wrap point.
- Drives registered 7-segment outputs of selectable polarity, plus tick, wrap and expiry status flags for the display/alarm logic.

Parameters:
- TICK_DIV, 10, sys_clk cycles per one-second tick; legal range 2..65535.
- HR_WRAP, 24, hour modulus; legal range 2..99. Count-up wraps from (HR_WRAP-1):59:59 to 00:00:00.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0; 0 = lit when bit is 1.

Ports:
- sys_clk  input  1  system clock.
- int_reset_b  input  1  reset, asynchronous, active-low.
- timer_clear  input  1  synchronous clear of digits, prescaler and flags.
- timer_pause  input  1  hold prescaler and digits.
- count_down  input  1  0 = count up, 1 = count down.
- load_en  input  1  one-cycle strobe that loads load_value.
- load_value  input  24  preset as six BCD nibbles; [3:0] = sec units … [23:20] = hr tens.
- digits_bcd  output  24  current BCD value, same packing as load_value.
- digital_clock_out  output  6x7  segment pattern per digit; index 0 = sec units … 5 = hr tens.
- tick_pulse  output  1  one-cycle pulse on each counted second.
- wrap_pulse  output  1  one-cycle pulse on count-up wrap to 00:00:00.
- expired  output  1  sticky; set when count-down reaches 00:00:00.

Behaviour:
- Reset values: digits_bcd = 0; all digital_clock_out entries = encoding of 0 (7'b0000001 when SEG_ACTIVE_LOW=1); tick_pulse, wrap_pulse, expired = 0; prescaler = 0.
- Per-cycle priority: timer_clear > load_en > timer_pause > normal counting.
- Prescaler:
  - Counts 0..TICK_DIV-1 while running.
  - When it equals TICK_DIV-1, it returns to 0 and a tick occurs.
  - Digits update on that same edge; tick_pulse is high the following cycle.
- timer_clear: digits = 0, prescaler = 0, expired = 0, no pulses. Clear takes priority over a simultaneous load_en.
- load_en:
  - Validity: every nibble ≤ 9; sec tens and min tens ≤ 5; hour value (hr tens*10 + hr units) < HR_WRAP.
  - Valid: digits = load_value, prescaler = 0, expired = 0.
  - Invalid: the load is ignored completely and counting continues.
  - Load has effect even while paused.
- timer_pause: prescaler and digits hold. No tick_pulse or wrap_pulse is generated. Flags hold.
- Count-up on tick:
  - Sec units carry at 9, sec tens at 5, min units at 9, min tens at 5.
  - Hours advance as a two-digit BCD value.
  - At (HR_WRAP-1):59:59, the next tick gives 00:00:00 and wrap_pulse fires one cycle after, aligned with tick_pulse.
- Count-down on tick:
  - Borrow chain is the mirror image of count-up.
  - The tick that reaches 00:00:00 sets expired.
  - At 00:00:00 with count_down=1, the value holds and no further ticks are produced; prescaler keeps running.
  - expired stays set until timer_clear or a valid load. Switching to count-up resumes counting but does not clear expired.
- count_down changes take effect at the next tick; no reset of the prescaler.
- Segment bit order is {a,b,c,d,e,f,g}, bit6 = a. Active-low patterns:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - SEG_ACTIVE_LOW=0 gives the bitwise inverse.
- digital_clock_out is registered from digits_bcd, so it lags digits_bcd by one cycle.
- Asserting int_reset_b low mid-count immediately forces all reset values, regardless of clock.

Test Plan:
- Count up, TICK_DIV=10, from reset → digits_bcd = 0x000001 after 10 cycles, then 0x000010 after 100 cycles; tick_pulse every 10th cycle; digital_clock_out[0] = 1001111 one cycle after digits show 1.
- Load 0x235959 (HR_WRAP=24), count up → next tick gives 0x000000 and wrap_pulse = 1 for exactly one cycle. Repeat with HR_WRAP=12, load 0x115959 → wraps to 0.
- Load 0x000003, count_down=1 → 3, 2, 1, 0 on successive ticks; expired rises with the 0 tick; value holds at 0 for 50 more cycles; switching to count-up gives 0x000001 and expired stays 1.
- Load 0x000100 with count down → 0x000059 on next tick (borrow across minutes). Load 0x000070 (invalid sec tens) → ignored, value unchanged.
- Pause for 37 cycles mid-prescale → digits and prescaler frozen, no tick_pulse; after resume, next tick arrives after the remaining cycles. timer_clear and load_en in the same cycle → result 0x000000.
- Drive int_reset_b low mid-count between clock edges → all outputs at reset values immediately; count resumes from 0 after release.
